entrada_codigo: RTL and testbench

- Parametrised successor to the vending machine's row/column digit-entry controller.
- Captures a product code of NUM_DIGITOS keypad digits, with an internal inactivity timeout, cancel, and lock-until-acknowledge.
- Sits between the keypad debouncer/encoder and the selection/payment logic.
- Presents the assembled code and holds it until the downstream stage pulses OK.

---
 rtl/entrada_codigo.sv | 150 +++++++++++++++
 tb/tb_entrada_codigo.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/entrada_codigo.sv
// entrada_codigo: keypad product-code entry controller.
// Collects NUM_DIGITOS digits (first digit in the MSBs of codigo), abandons an
// idle entry after TIMEOUT_CICLOS cycles, aborts on cancela, and holds a
// complete code until the downstream stage acknowledges it with OK.
// Optional backspace support is compiled in with `define ENTRADA_CODIGO_APAGA_EN;
// without it the apaga port is present but has no effect.
module entrada_codigo #(
    parameter int NUM_DIGITOS    = 2,
    parameter int LARGURA_DIGITO = 4,
    parameter int TIMEOUT_CICLOS = 1000,
    localparam int IW = (NUM_DIGITOS > 1) ? $clog2(NUM_DIGITOS + 1) : 1,
    localparam int CW = $clog2(TIMEOUT_CICLOS)
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  tecla_valida,
    input  logic [LARGURA_DIGITO-1:0]             tecla,
    input  logic                                  cancela,
    input  logic                                  apaga,
    input  logic                                  OK,
    output logic [NUM_DIGITOS*LARGURA_DIGITO-1:0] codigo,
    output logic                                  codigo_valido,
    output logic [IW-1:0]                         indice,
    output logic                                  ocupado,
    output logic                                  clear,
    output logic                                  estouro_tempo
);

    typedef enum logic [1:0] {ESPERA, CAPTURA, BLOQUEADO} estado_t;

    estado_t estado, proxEstado;

    logic [NUM_DIGITOS-1:0][LARGURA_DIGITO-1:0] slots;
    logic [CW-1:0]             cont, contProx;
    logic [IW-1:0]             indiceProx, idxEscrita;
    logic [LARGURA_DIGITO-1:0] dadoEscrita;
    logic                      escreve, zeraTudo, expira, apagaEf;

`ifdef ENTRADA_CODIGO_APAGA_EN
    assign apagaEf = apaga;
`else
    logic unusedApaga;
    assign unusedApaga = apaga;
    assign apagaEf     = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) estado <= ESPERA;
        else     estado <= proxEstado;
    end

    // Next-state logic; cancela outranks backspace, keys and timeout
    always_comb begin
        proxEstado = estado;
        case (estado)
            ESPERA: begin
                if (!cancela && tecla_valida)
                    proxEstado = (NUM_DIGITOS == 1) ? BLOQUEADO : CAPTURA;
            end
            CAPTURA: begin
                if (cancela)
                    proxEstado = ESPERA;
                else if (apagaEf) begin
                    if (indice == IW'(1)) proxEstado = ESPERA;
                end else if (tecla_valida) begin
                    if (indice == IW'(NUM_DIGITOS - 1)) proxEstado = BLOQUEADO;
                end else if (cont == CW'(TIMEOUT_CICLOS - 1))
                    proxEstado = ESPERA;
            end
            BLOQUEADO: begin
                if (OK) proxEstado = ESPERA;
            end
            default: proxEstado = ESPERA;
        endcase
    end

    // Output decode from the registered state
    always_comb begin
        clear         = (estado == ESPERA);
        ocupado       = (estado == CAPTURA);
        codigo_valido = (estado == BLOQUEADO);
    end

    // Datapath control: which slot to write, next digit count and idle counter.
    // Any transition into ESPERA wipes everything on the same edge.
    always_comb begin
        zeraTudo    = (proxEstado == ESPERA);
        escreve     = 1'b0;
        idxEscrita  = indice;
        dadoEscrita = tecla;
        indiceProx  = indice;
        contProx    = cont;
        expira      = 1'b0;
        if (zeraTudo) begin
            indiceProx = '0;
            contProx   = '0;
            // Only an idle CAPTURA cycle can reach ESPERA without a cause input
            expira = (estado == CAPTURA) && !cancela && !apagaEf && !tecla_valida;
        end else begin
            case (estado)
                ESPERA: begin
                    escreve    = 1'b1;
                    idxEscrita = '0;
                    indiceProx = IW'(1);
                end
                CAPTURA: begin
                    if (apagaEf) begin
                        escreve     = 1'b1;
                        idxEscrita  = indice - IW'(1);
                        dadoEscrita = '0;
                        indiceProx  = indice - IW'(1);
                        contProx    = '0;
                    end else if (tecla_valida) begin
                        escreve    = 1'b1;
                        indiceProx = indice + IW'(1);
                        contProx   = '0;
                    end else begin
                        contProx = cont + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Digit count, idle counter and timeout pulse registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            indice        <= '0;
            cont          <= '0;
            estouro_tempo <= 1'b0;
        end else begin
            indice        <= indiceProx;
            cont          <= contProx;
            estouro_tempo <= expira;
        end
    end

    // One register per digit slot; slot 0 lands in the MSBs of codigo
    for (genvar i = 0; i < NUM_DIGITOS; i++) begin : g_slot
        always_ff @(posedge clk or posedge rst) begin
            if (rst)                                 slots[i] <= '0;
            else if (zeraTudo)                       slots[i] <= '0;
            else if (escreve && idxEscrita == IW'(i)) slots[i] <= dadoEscrita;
        end
        assign codigo[(NUM_DIGITOS-1-i)*LARGURA_DIGITO +: LARGURA_DIGITO] = slots[i];
    end

endmodule

// File: tb/tb_entrada_codigo.sv
// Directed bench for entrada_codigo: three instances (2, 3 and 1 digit codes)
// share the stimulus; each section resets first and checks one instance.
// Expectations follow ENTRADA_CODIGO_APAGA_EN when it is defined.
module tb_entrada_codigo;

    logic clk = 1'b0;
    logic rst;
    logic tv, cancela, apaga, OK;
    logic [3:0] tecla;

    logic [7:0]  codigo2;
    logic [1:0]  indice2;
    logic        valido2, ocupado2, clear2, estouro2;
    logic [11:0] codigo3;
    logic [1:0]  indice3;
    logic        valido3, ocupado3, clear3, estouro3;
    logic [3:0]  codigo1;
    logic [0:0]  indice1;
    logic        valido1, ocupado1, clear1, estouro1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    entrada_codigo #(.NUM_DIGITOS(2), .LARGURA_DIGITO(4), .TIMEOUT_CICLOS(1000)) dut2 (
        .clk(clk), .rst(rst), .tecla_valida(tv), .tecla(tecla), .cancela(cancela),
        .apaga(apaga), .OK(OK), .codigo(codigo2), .codigo_valido(valido2),
        .indice(indice2), .ocupado(ocupado2), .clear(clear2), .estouro_tempo(estouro2));

    entrada_codigo #(.NUM_DIGITOS(3), .LARGURA_DIGITO(4), .TIMEOUT_CICLOS(20)) dut3 (
        .clk(clk), .rst(rst), .tecla_valida(tv), .tecla(tecla), .cancela(cancela),
        .apaga(apaga), .OK(OK), .codigo(codigo3), .codigo_valido(valido3),
        .indice(indice3), .ocupado(ocupado3), .clear(clear3), .estouro_tempo(estouro3));

    entrada_codigo #(.NUM_DIGITOS(1), .LARGURA_DIGITO(4), .TIMEOUT_CICLOS(2)) dut1 (
        .clk(clk), .rst(rst), .tecla_valida(tv), .tecla(tecla), .cancela(cancela),
        .apaga(apaga), .OK(OK), .codigo(codigo1), .codigo_valido(valido1),
        .indice(indice1), .ocupado(ocupado1), .clear(clear1), .estouro_tempo(estouro1));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        tv = 0; cancela = 0; apaga = 0; OK = 0; tecla = 0;
        rst = 1;
        step();
        rst = 0;
    endtask

    task automatic key(input logic [3:0] d);
        tv = 1; tecla = d;
        step();
        tv = 0;
    endtask

    initial begin
        tv = 0; cancela = 0; apaga = 0; OK = 0; tecla = 0; rst = 1;
        step(); step();
        // reset values on every instance
        chk("rst2", {codigo2, 2'b0, indice2, valido2, ocupado2, clear2, estouro2}, 32'h0000_0002);
        chk("rst3", {codigo3, 2'b0, indice3, valido3, ocupado3, clear3, estouro3}, 32'h0000_0002);
        chk("rst1", {codigo1, 3'b0, indice1, valido1, ocupado1, clear1, estouro1}, 32'h0000_0002);
        rst = 0;

        // asynchronous reset in the middle of an entry
        key(4'h3);
        chk("cap1_codigo", codigo2, 8'h30);
        chk("cap1_indice", indice2, 2'd1);
        chk("cap1_ocupado", ocupado2, 1'b1);
        #2 rst = 1;
        #1;
        chk("arst_codigo", codigo2, 8'h00);
        chk("arst_flags", {indice2, ocupado2, clear2}, {2'd0, 1'b0, 1'b1});
        #1 rst = 0;
        step();

        // two-digit code, acknowledged five cycles later
        doReset();
        key(4'h3);
        key(4'h7);
        chk("code37", codigo2, 8'h37);
        chk("code37_valid", {valido2, ocupado2, indice2}, {1'b1, 1'b0, 2'd2});
        for (int i = 0; i < 4; i++) step();
        chk("hold37", {codigo2, valido2}, {8'h37, 1'b1});
        OK = 1;
        step();
        OK = 0;
        chk("ok_release", {codigo2, valido2, clear2, indice2}, {8'h00, 1'b0, 1'b1, 2'd0});

        // inactivity timeout
        doReset();
        key(4'h5);
        for (int i = 0; i < 999; i++) step();
        chk("pre_timeout", {ocupado2, estouro2, codigo2}, {1'b1, 1'b0, 8'h50});
        step();
        chk("timeout", {estouro2, clear2, codigo2, indice2}, {1'b1, 1'b1, 8'h00, 2'd0});
        step();
        chk("timeout_pulse_end", estouro2, 1'b0);

        // key on the expiry cycle wins
        doReset();
        key(4'h5);
        for (int i = 0; i < 999; i++) step();
        key(4'h9);
        chk("expiry_key", {codigo2, valido2, estouro2}, {8'h59, 1'b1, 1'b0});

        // cancela beats a simultaneous key
        doReset();
        key(4'h2);
        cancela = 1;
        key(4'h4);
        cancela = 0;
        chk("cancel", {codigo2, indice2, clear2}, {8'h00, 2'd0, 1'b1});
        // cancela and keys ignored while locked
        key(4'h3);
        key(4'h7);
        cancela = 1;
        key(4'h1);
        step();
        cancela = 0;
        chk("locked", {codigo2, valido2, indice2}, {8'h37, 1'b1, 2'd2});

        // three-digit entry with backspace
        doReset();
        key(4'h1);
        chk("d3_k1", {indice3, codigo3}, {2'd1, 12'h100});
        key(4'h4);
        chk("d3_k4", {indice3, codigo3}, {2'd2, 12'h140});
        apaga = 1;
        step();
        apaga = 0;
`ifdef ENTRADA_CODIGO_APAGA_EN
        chk("d3_apaga", {indice3, codigo3}, {2'd1, 12'h100});
        key(4'h9);
        chk("d3_k9", {indice3, codigo3, ocupado3}, {2'd2, 12'h190, 1'b1});
        key(4'h6);
        chk("d3_k6", {codigo3, valido3}, {12'h196, 1'b1});
`else
        chk("d3_apaga", {indice3, codigo3}, {2'd2, 12'h140});
        key(4'h9);
        chk("d3_k9", {indice3, codigo3, valido3}, {2'd3, 12'h149, 1'b1});
        key(4'h6);
        chk("d3_k6", {codigo3, valido3}, {12'h149, 1'b1});
`endif

        // one key then backspace together with a key
        doReset();
        key(4'h1);
        apaga = 1;
        key(4'h8);
        apaga = 0;
`ifdef ENTRADA_CODIGO_APAGA_EN
        chk("d3_apaga_empty", {clear3, indice3, codigo3, estouro3}, {1'b1, 2'd0, 12'h000, 1'b0});
`else
        chk("d3_apaga_empty", {ocupado3, indice3, codigo3}, {1'b1, 2'd2, 12'h180});
`endif

        // backspace on the two-digit instance
        doReset();
        key(4'h3);
        apaga = 1;
        step();
        apaga = 0;
`ifdef ENTRADA_CODIGO_APAGA_EN
        chk("d2_apaga", {clear2, indice2, codigo2}, {1'b1, 2'd0, 8'h00});
        key(4'h7);
        chk("d2_after", {ocupado2, indice2, codigo2}, {1'b1, 2'd1, 8'h70});
`else
        chk("d2_apaga", {ocupado2, indice2, codigo2}, {1'b1, 2'd1, 8'h30});
        key(4'h7);
        chk("d2_after", {valido2, codigo2}, {1'b1, 8'h37});
`endif

        // single-digit code
        doReset();
        key(4'hA);
        chk("d1_lock", {codigo1, valido1, indice1, ocupado1}, {4'hA, 1'b1, 1'b1, 1'b0});
        key(4'h5);
        chk("d1_frozen", {codigo1, valido1}, {4'hA, 1'b1});
        OK = 1;
        step();
        OK = 0;
        chk("d1_ok", {codigo1, clear1, valido1}, {4'h0, 1'b1, 1'b0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
